// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory bus bundle for the data memory arbiter
interface dmem_arbiter_if #(
   parameter int AW = 7,
   parameter int DW = 32
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          rvalid0;
   logic [DW-1:0] rdata0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          rvalid1;
   logic [DW-1:0] rdata1;

   logic          CEN;
   logic          WEN;
   logic          OEN;
   logic [AW-1:0] A;
   logic [DW-1:0] D;
   logic [DW-1:0] Q;
   logic          busy;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  Q,
      output gnt0, rvalid0, rdata0,
      output gnt1, rvalid1, rdata1,
      output CEN, WEN, OEN, A, D, busy
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output Q,
      input  gnt0, rvalid0, rdata0,
      input  gnt1, rvalid1, rdata1,
      input  CEN, WEN, OEN, A, D, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a synchronous data memory
module dmem_arbiter #(
   parameter int AW = 7,
   parameter int DW = 32
) (
   input logic           CLK,
   input logic           RST,
   dmem_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state;
   logic          prio;      // port favoured when both request
   logic          port;      // winner of the access in flight
   logic          we_l;
   logic [AW-1:0] addr_l;
   logic [DW-1:0] wdata_l;
   logic          rvalid0_r;
   logic          rvalid1_r;
   logic [DW-1:0] rdata0_r;
   logic [DW-1:0] rdata1_r;
   logic          win;

   // pick the winner: a lone requester wins, a tie goes to the favoured port
   always_comb begin
      win = prio;
      if (bus.req0 && !bus.req1) begin
         win = 1'b0;
      end else if (bus.req1 && !bus.req0) begin
         win = 1'b1;
      end
   end

   // state sequencing and round-robin pointer update
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         prio  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  prio  <= ~win;
                  state <= ACC;
               end
            end
            ACC:     state <= we_l ? IDLE : RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // capture the winning request only at the arbitration edge so later input changes cannot leak in
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         port    <= 1'b0;
         we_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
      end else if (state == IDLE && (bus.req0 || bus.req1)) begin
         port    <= win;
         we_l    <= win ? bus.we1    : bus.we0;
         addr_l  <= win ? bus.addr1  : bus.addr0;
         wdata_l <= win ? bus.wdata1 : bus.wdata0;
      end
   end

   // read completion: register Q at the end of RESP and pulse rvalid for one cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         rdata0_r  <= '0;
         rdata1_r  <= '0;
      end else begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         if (state == RESP) begin
            if (port) begin
               rdata1_r  <= bus.Q;
               rvalid1_r <= 1'b1;
            end else begin
               rdata0_r  <= bus.Q;
               rvalid0_r <= 1'b1;
            end
         end
      end
   end

   // memory strobes decode straight from state; A and D hold the latched access
   assign bus.gnt0    = (state == ACC) && !port;
   assign bus.gnt1    = (state == ACC) &&  port;
   assign bus.CEN     = !(state == ACC);
   assign bus.WEN     = !((state == ACC) && we_l);
   assign bus.OEN     = !(((state == ACC) && !we_l) || (state == RESP));
   assign bus.A       = addr_l;
   assign bus.D       = wdata_l;
   assign bus.busy    = (state != IDLE);
   assign bus.rvalid0 = rvalid0_r;
   assign bus.rvalid1 = rvalid1_r;
   assign bus.rdata0  = rdata0_r;
   assign bus.rdata1  = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for the data memory arbiter
module tb_dmem_arbiter;

   logic CLK;
   logic RST;

   dmem_arbiter_if #(.AW(7), .DW(32)) bus ();

   dmem_arbiter #(.AW(7), .DW(32)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        port;
      logic        we;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } sb_t;

   sb_t  sbq[$];
   vec_t tbl[12];
   int   total = 0;
   int   bad   = 0;

   logic [31:0] mem [128];

   // synchronous memory model: write and read sampled on the edge ending the address cycle
   always @(posedge CLK) begin
      if (!bus.CEN) begin
         if (!bus.WEN) mem[bus.A] <= bus.D;
         bus.Q <= mem[bus.A];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // scoreboard: every rvalid must match the oldest pending read; grants never overlap
   always @(negedge CLK) begin
      if (bus.gnt0 || bus.gnt1) chk("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 0);
      if (bus.rvalid0 || bus.rvalid1) begin
         chk("rvalid_onehot", 32'(bus.rvalid0 & bus.rvalid1), 0);
         if (sbq.size() == 0) begin
            chk("unexpected_rvalid", 32'(bus.rvalid1), 32'hFFFF_FFFF);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("sb_port", 32'(bus.rvalid1), 32'(e.port));
            chk("sb_data", bus.rvalid1 ? bus.rdata1 : bus.rdata0, e.data);
         end
      end
   end

   task automatic drive(input logic p, input logic r, input logic we,
                        input logic [6:0] addr, input logic [31:0] wdata);
      if (p) begin
         bus.req1 = r; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
      end else begin
         bus.req0 = r; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
      end
   endtask

   task automatic push(input logic p, input logic [31:0] d);
      sb_t e;
      e.port = p;
      e.data = d;
      sbq.push_back(e);
   endtask

   task automatic do_access(input vec_t v);
      @(negedge CLK);
      drive(v.port, 1'b1, v.we, v.addr, v.wdata);
      @(negedge CLK);
      chk("acc_gnt",   32'(v.port ? bus.gnt1 : bus.gnt0), 1);
      chk("acc_other", 32'(v.port ? bus.gnt0 : bus.gnt1), 0);
      chk("acc_cen",   32'(bus.CEN), 0);
      chk("acc_wen",   32'(bus.WEN), 32'(!v.we));
      chk("acc_oen",   32'(bus.OEN), 32'(v.we));
      chk("acc_a",     32'(bus.A), 32'(v.addr));
      chk("acc_busy",  32'(bus.busy), 1);
      if (v.we) chk("acc_d", bus.D, v.wdata);
      drive(v.port, 1'b0, v.we, v.addr, v.wdata);
      if (!v.we) push(v.port, v.exp);
      @(negedge CLK);
      if (v.we) begin
         chk("wr_idle_busy", 32'(bus.busy), 0);
         chk("wr_idle_cen",  32'(bus.CEN), 1);
      end else begin
         chk("resp_cen",  32'(bus.CEN), 1);
         chk("resp_oen",  32'(bus.OEN), 0);
         chk("resp_wen",  32'(bus.WEN), 1);
         chk("resp_gnt",  32'(bus.gnt0 | bus.gnt1), 0);
         @(negedge CLK);
         chk("rd_rvalid", 32'(v.port ? bus.rvalid1 : bus.rvalid0), 1);
         chk("rd_rdata",  v.port ? bus.rdata1 : bus.rdata0, v.exp);
         chk("rd_busy",   32'(bus.busy), 0);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cen"},    32'(bus.CEN), 1);
      chk({tag, "_wen"},    32'(bus.WEN), 1);
      chk({tag, "_oen"},    32'(bus.OEN), 1);
      chk({tag, "_a"},      32'(bus.A), 0);
      chk({tag, "_d"},      bus.D, 0);
      chk({tag, "_gnt"},    32'(bus.gnt0 | bus.gnt1), 0);
      chk({tag, "_rvalid"}, 32'(bus.rvalid0 | bus.rvalid1), 0);
      chk({tag, "_rdata0"}, bus.rdata0, 0);
      chk({tag, "_rdata1"}, bus.rdata1, 0);
      chk({tag, "_busy"},   32'(bus.busy), 0);
   endtask

   initial begin
      vec_t v;
      tbl[0]  = '{1'b0, 1'b1, 7'd5,   32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 7'd5,   32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 1'b1, 7'd2,   32'h1234_5678, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 7'd1,   32'hA5A5_A5A5, 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 7'd127, 32'hFFFF_0000, 32'h0};
      tbl[5]  = '{1'b0, 1'b1, 7'd3,   32'h3333_3333, 32'h0};
      tbl[6]  = '{1'b1, 1'b1, 7'd9,   32'h9999_9999, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, 7'd5,   32'h0,         32'hDEAD_BEEF};
      tbl[8]  = '{1'b1, 1'b0, 7'd2,   32'h0,         32'h1234_5678};
      tbl[9]  = '{1'b0, 1'b0, 7'd127, 32'h0,         32'hFFFF_0000};
      tbl[10] = '{1'b0, 1'b0, 7'd1,   32'h0,         32'hA5A5_A5A5};
      tbl[11] = '{1'b1, 1'b0, 7'd0,   32'h0,         32'h0000_0000};

      RST = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
      drive(1'b1, 1'b0, 1'b1, 7'd0, 32'h0);
      bus.req1 = 1'b1;
      // address 0 gets a known value before its read in the table
      mem[0] = 32'h0000_0000;
      repeat (2) @(negedge CLK);
      chk_reset_outputs("rst");
      bus.req1 = 1'b0;
      RST = 1'b0;

      foreach (tbl[i]) do_access(tbl[i]);

      // simultaneous reads right after reset: port 0 first, port 1 next
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 7'd1, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 7'd2, 32'h0);
      @(negedge CLK);
      chk("tie_gnt0", 32'(bus.gnt0), 1);
      chk("tie_gnt1_wait", 32'(bus.gnt1), 0);
      chk("tie_a0", 32'(bus.A), 1);
      push(1'b0, 32'hA5A5_A5A5);
      push(1'b1, 32'h1234_5678);
      bus.req0 = 1'b0;
      repeat (2) @(negedge CLK);
      chk("tie_rdata0", bus.rdata0, 32'hA5A5_A5A5);
      @(negedge CLK);
      chk("tie_gnt1", 32'(bus.gnt1), 1);
      chk("tie_a1", 32'(bus.A), 2);
      bus.req1 = 1'b0;
      repeat (2) @(negedge CLK);
      chk("tie_rdata1", bus.rdata1, 32'h1234_5678);

      // both requests held for six grants: strict alternation starting at port 0
      @(negedge CLK);
      drive(1'b0, 1'b1, 1'b1, 7'd100, 32'h0000_0100);
      drive(1'b1, 1'b1, 1'b1, 7'd101, 32'h0000_0101);
      for (int g = 0; g < 6; g++) begin
         int n = 0;
         @(negedge CLK);
         while (!(bus.gnt0 || bus.gnt1) && n < 10) begin
            @(negedge CLK);
            n++;
         end
         if (n >= 10) chk("rr_timeout", 32'(n), 0);
         chk("rr_port", 32'(bus.gnt1), 32'(g % 2));
         if (g == 5) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end
      end
      repeat (3) begin
         @(negedge CLK);
         chk("rr_quiet", 32'(bus.gnt0 | bus.gnt1), 0);
      end

      // address change in the grant cycle must not reach the memory
      drive(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
      @(negedge CLK);
      chk("hold_gnt", 32'(bus.gnt0), 1);
      chk("hold_a_acc", 32'(bus.A), 3);
      push(1'b0, 32'h3333_3333);
      drive(1'b0, 1'b0, 1'b1, 7'd9, 32'hFFFF_FFFF);
      @(negedge CLK);
      chk("hold_a_resp", 32'(bus.A), 3);
      @(negedge CLK);
      chk("hold_rdata", bus.rdata0, 32'h3333_3333);

      // reset in the middle of a port-1 read aborts it
      drive(1'b1, 1'b1, 1'b0, 7'd2, 32'h0);
      @(negedge CLK);
      chk("abort_gnt", 32'(bus.gnt1), 1);
      bus.req1 = 1'b0;
      @(negedge CLK);
      chk("abort_resp_busy", 32'(bus.busy), 1);
      RST = 1'b1;
      #1;
      chk_reset_outputs("abort");
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         chk("abort_no_rvalid", 32'(bus.rvalid1), 0);
      end
      v = '{1'b1, 1'b0, 7'd2, 32'h0, 32'h1234_5678};
      do_access(v);

      repeat (2) @(negedge CLK);
      chk("sb_drained", 32'(sbq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
